// File: rtl/mat_mac_engine.sv
// mat_mac_engine -- small NxN matrix multiply engine, C = A x B.
//
// Operands are streamed in through a valid/ready load port (A then B,
// row-major, 2*N*N words). A start pulse in READY runs one MAC per clock
// over k for each result element (i,j), then stores the sum. Results are
// read back one byte at a time through a registered read port.
//
// Build option: define MATMUL_SIGNED_EN for two's-complement operands,
// a signed MAC and sign-extended read-back of the top byte. Without it,
// operands are unsigned and the top byte is zero-filled.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   load_valid  load_data valid this cycle
//   load_data   operand word [DW]
//   load_ready  engine accepts a load word this cycle
//   start       begin multiplication (honoured in READY only)
//   busy        high in CALC and STORE
//   done        one-cycle completion pulse
//   rd_addr     result index i*N+j
//   rd_part     result byte select, 0 = LSB
//   rd_data     selected result byte, one cycle after rd_addr/rd_part
//
// state | meaning
// IDLE  | waiting for the first operand word
// LOAD  | receiving operand words
// READY | operands complete, waiting for start
// CALC  | one MAC per cycle over k
// STORE | write acc to result memory, advance j then i
// DONE  | pulse done, return to IDLE

module mat_mac_engine #(
   parameter int DW = 8,
   parameter int N  = 3,
   localparam int ACCW  = 2*DW + $clog2(N),
   localparam int PARTS = (ACCW + 7) / 8,
   localparam int AW    = $clog2(N*N),
   localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_ready,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic [AW-1:0] rd_addr,
   input  logic [PW-1:0] rd_part,
   output logic [7:0]    rd_data
);

   localparam int NN = N*N;
   localparam int OW = $clog2(2*NN);
   localparam int IW = $clog2(N);
   localparam int XW = PARTS*8;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_READY, S_CALC, S_STORE, S_DONE
   } state_t;

   state_t          state;
   logic [OW-1:0]   wptr;
   logic [IW-1:0]   i, j, k;
   logic [ACCW-1:0] acc;
   logic [DW-1:0]   op_mem  [2*NN];
   logic [ACCW-1:0] res_mem [NN];

   logic            accept;
   logic [OW-1:0]   a_idx, b_idx;
   logic [AW-1:0]   r_idx;
   logic [DW-1:0]   a_word, b_word;
   logic [2*DW-1:0] prod;
   logic [ACCW-1:0] mac_term;
   logic [XW-1:0]   rd_ext;
   logic            rd_fill;
   logic            addr_ok;
   logic [7:0]      rd_byte;

   // load_ready is registered alongside the state, so it is exactly
   // "state is IDLE or LOAD".
   assign accept = load_valid && load_ready;

   always_comb begin
      a_idx  = OW'(i) * OW'(N) + OW'(k);
      b_idx  = OW'(NN) + OW'(k) * OW'(N) + OW'(j);
      r_idx  = AW'(i) * AW'(N) + AW'(j);
      a_word = op_mem[a_idx];
      b_word = op_mem[b_idx];
`ifdef MATMUL_SIGNED_EN
      // Operands widened to 2*DW first so the low 2*DW bits of the
      // product are the exact signed result.
      prod     = $signed({{DW{a_word[DW-1]}}, a_word}) *
                 $signed({{DW{b_word[DW-1]}}, b_word});
      mac_term = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
`else
      prod     = {{DW{1'b0}}, a_word} * {{DW{1'b0}}, b_word};
      mac_term = {{(ACCW-2*DW){1'b0}}, prod};
`endif
   end

   always_comb begin
      addr_ok = int'(rd_addr) < NN;
      rd_ext  = '0;
      if (addr_ok) begin
         rd_ext[ACCW-1:0] = res_mem[rd_addr];
      end
`ifdef MATMUL_SIGNED_EN
      rd_fill = rd_ext[ACCW-1];
`else
      rd_fill = 1'b0;
`endif
      for (int b = ACCW; b < XW; b++) begin
         rd_ext[b] = rd_fill;
      end
      rd_byte = '0;
      for (int p = 0; p < PARTS; p++) begin
         if (addr_ok && int'(rd_part) == p) begin
            rd_byte = rd_ext[p*8 +: 8];
         end
      end
   end

   // Operand memory carries no reset; it is fully rewritten by each load.
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         op_mem[wptr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wptr       <= '0;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         acc        <= '0;
         rd_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b1;
         for (int e = 0; e < NN; e++) begin
            res_mem[e] <= '0;
         end
      end else begin
         done    <= 1'b0;
         rd_data <= rd_byte;
         case (state)
            S_IDLE, S_LOAD: begin
               if (accept) begin
                  if (wptr == OW'(2*NN-1)) begin
                     wptr       <= '0;
                     state      <= S_READY;
                     load_ready <= 1'b0;
                  end else begin
                     wptr  <= wptr + 1'b1;
                     state <= S_LOAD;
                  end
               end
            end
            S_READY: begin
               if (start) begin
                  acc   <= '0;
                  i     <= '0;
                  j     <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               acc <= acc + mac_term;
               if (k == IW'(N-1)) begin
                  k     <= '0;
                  state <= S_STORE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_STORE: begin
               res_mem[r_idx] <= acc;
               acc            <= '0;
               state          <= S_CALC;
               if (j == IW'(N-1)) begin
                  j <= '0;
                  if (i == IW'(N-1)) begin
                     i     <= '0;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     i <= i + 1'b1;
                  end
               end else begin
                  j <= j + 1'b1;
               end
            end
            S_DONE: begin
               done       <= 1'b1;
               load_ready <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               state      <= S_IDLE;
               busy       <= 1'b0;
               load_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mat_mac_engine.sv
// Testbench for mat_mac_engine (DW=8, N=3). Reads are issued by the
// stimulus side, which pushes the expected byte from a plain-arithmetic
// matrix model; a monitor pops and compares when rd_data is presented.

module tb_mat_mac_engine;
   localparam int DW    = 8;
   localparam int N     = 3;
   localparam int NN    = N*N;
   localparam int PARTS = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic          start;
   logic          busy;
   logic          done;
   logic [3:0]    rd_addr;
   logic [1:0]    rd_part;
   logic [7:0]    rd_data;

   always #5 clk = ~clk;

   mat_mac_engine #(.DW(DW), .N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .rd_addr    (rd_addr),
      .rd_part    (rd_part),
      .rd_data    (rd_data)
   );

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] words [2*NN];
   int            exp_res [NN];
   int            exp_q [$];
   int            tag_q [$];
   logic          rd_issue = 1'b0;
   logic          rd_issue_q = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int opv(input logic [DW-1:0] w);
`ifdef MATMUL_SIGNED_EN
      return int'($signed(w));
`else
      return int'(w);
`endif
   endfunction

   function automatic void compute_model();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            int s = 0;
            for (int m = 0; m < N; m++)
               s += opv(words[r*N+m]) * opv(words[NN+m*N+c]);
            exp_res[r*N+c] = s;
         end
   endfunction

   function automatic int exp_byte(input int a, input int p);
      if (a >= NN || p >= PARTS) return 0;
      return (exp_res[a] >>> (8*p)) & 255;
   endfunction

   // scoreboard monitor
   always @(posedge clk) rd_issue_q <= rd_issue;

   always @(negedge clk) begin
      int e, t;
      if (rd_issue_q) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rd_underflow: read returned %0d with no expectation queued", rd_data);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (int'(rd_data) !== e) begin
               fails++;
               $display("FAIL rd addr=%0d part=%0d: got 0x%02h expected 0x%02h",
                        t / 16, t % 16, rd_data, e[7:0]);
            end
         end
      end
   end

   task automatic read_all();
      int addrs [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 15};
      foreach (addrs[x])
         for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            rd_addr  = 4'(addrs[x]);
            rd_part  = 2'(p);
            rd_issue = 1'b1;
            exp_q.push_back(exp_byte(addrs[x], p));
            tag_q.push_back(addrs[x]*16 + p);
         end
      @(negedge clk);
      rd_issue = 1'b0;
      @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      foreach (exp_res[x]) exp_res[x] = 0;
   endtask

   task automatic load_words(input int from, input int to, input bit start_on_last);
      for (int w = from; w <= to; w++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            load_valid = 1'b0;
            @(negedge clk);
         end
         load_valid = 1'b1;
         load_data  = words[w];
         if (start_on_last && w == to) start = 1'b1;
         check("load_ready_during_load", load_ready, 1);
         @(posedge clk);
         #1;
         load_valid = 1'b0;
         start      = 1'b0;
      end
   endtask

   task automatic run_calc(input bit hold_valid);
      int cnt = 0;
      bit got = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (cnt < 100 && !got) begin
         @(negedge clk);
         if (cnt == 0) check("busy_after_start", busy, 1);
         if (done) got = 1;
         else begin
            if (hold_valid) begin
               load_valid = 1'b1;
               load_data  = DW'($urandom);
            end
            @(posedge clk);
            cnt++;
         end
      end
      load_valid = 1'b0;
      check("done_latency", got ? cnt : -1, NN*(N+1)+1);
      check("busy_at_done", busy, 0);
      @(negedge clk);
      check("done_single_cycle", done, 0);
      check("load_ready_after_done", load_ready, 1);
      compute_model();
   endtask

   task automatic fill_random();
      foreach (words[x]) words[x] = DW'($urandom);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
      rd_addr = '0; rd_part = '0;
      do_reset();
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_load_ready", load_ready, 1);
      read_all();

      // A = identity, B = 1..9
      for (int x = 0; x < NN; x++) begin
         words[x]    = (x / N == x % N) ? DW'(1) : DW'(0);
         words[NN+x] = DW'(x + 1);
      end
      load_words(0, 2*NN-1, 0);
      run_calc(0);
      for (int x = 0; x < NN; x++) check("identity_model", exp_res[x], x + 1);
      read_all();

      // all 0xFF
      foreach (words[x]) words[x] = 8'hFF;
      load_words(0, 2*NN-1, 0);
      run_calc(0);
      read_all();

      // A all 0xFF, B all 0x02
      for (int x = 0; x < NN; x++) begin
         words[x]    = 8'hFF;
         words[NN+x] = 8'h02;
      end
      load_words(0, 2*NN-1, 0);
      run_calc(0);
      read_all();

      // random operands
      repeat (3) begin
         fill_random();
         load_words(0, 2*NN-1, 0);
         run_calc(0);
         read_all();
      end

      // start before the load completes, and together with the final word
      fill_random();
      load_words(0, 2*NN-2, 0);
      repeat (3) begin
         @(negedge clk);
         start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         @(negedge clk);
         check("early_start_busy", busy, 0);
         check("early_start_still_loading", load_ready, 1);
      end
      load_words(2*NN-1, 2*NN-1, 1);
      @(negedge clk);
      check("final_word_start_busy", busy, 0);
      check("final_word_ready_state", load_ready, 0);
      repeat (2) @(negedge clk);
      check("ready_waits_busy", busy, 0);
      run_calc(0);
      read_all();

      // load_valid held high through the computation
      fill_random();
      load_words(0, 2*NN-1, 0);
      run_calc(1);
      read_all();

      // reset in the middle of CALC
      fill_random();
      load_words(0, 2*NN-1, 0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("busy_before_mid_reset", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      foreach (exp_res[x]) exp_res[x] = 0;
      @(negedge clk);
      check("mid_reset_busy", busy, 0);
      check("mid_reset_load_ready", load_ready, 1);
      check("mid_reset_done", done, 0);
      read_all();
      fill_random();
      load_words(0, 2*NN-1, 0);
      run_calc(0);
      read_all();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mat_mac_engine.md
MAT_MAC_ENGINE -- requirements
Module: mat_mac_engine

Interface
REQ-001 SHALL have parameter DW, default 8: operand width in bits, 2..16.
REQ-002 SHALL have parameter N, default 3: square matrix dimension, 2..8.
REQ-003 SHALL derive ACCW = 2*DW + ceil(log2(N)) (default 18), the result width, and PARTS = ceil(ACCW/8) (default 3).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port load_valid, input, 1 bit: load_data is valid this cycle.
REQ-007 SHALL have port load_data, input, DW bits: operand word, A then B, row-major.
REQ-008 SHALL have port load_ready, output, 1 bit: the engine accepts a load word this cycle.
REQ-009 SHALL have port start, input, 1 bit: begin multiplication.
REQ-010 SHALL have port busy, output, 1 bit: computation in progress.
REQ-011 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port rd_addr, input, clog2(N*N) bits: result index, i*N+j.
REQ-013 SHALL have port rd_part, input, clog2(PARTS) bits (minimum 1): result byte select, 0 = LSB.
REQ-014 SHALL have port rd_data, output, 8 bits: the selected result byte.

Function
REQ-015 SHALL use FSM states IDLE, LOAD, READY, CALC, STORE, DONE.
REQ-016 SHALL assert load_ready in IDLE and LOAD only, and accept a word on each cycle where load_valid && load_ready.
REQ-017 SHALL write each accepted word to operand memory at wptr and then increment wptr; the first accepted word moves IDLE->LOAD.
REQ-018 SHALL move LOAD->READY on acceptance of word 2*N*N-1 and clear wptr at that point.
REQ-019 SHALL ignore start in IDLE, LOAD, CALC and STORE; in the same cycle as the final load word, the word SHALL be accepted and start ignored.
REQ-020 SHALL, on start in READY, clear the accumulator, set i=j=k=0 and enter CALC.
REQ-021 SHALL perform in CALC one MAC per cycle, acc += A[i][k]*B[k][j], for k=0..N-1, then enter STORE.
REQ-022 SHALL, in STORE, write acc (ACCW bits, no overflow possible) to result[i*N+j], clear acc, and advance j, then i.
REQ-023 SHALL, after the STORE of element N*N-1, enter DONE; DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-024 SHALL produce done exactly N*N*(N+1)+1 cycles after the start edge (37 for N=3).
REQ-025 SHALL assert busy in CALC and STORE only.
REQ-026 SHALL register rd_data with 1-cycle latency from rd_addr/rd_part.
REQ-027 SHALL return 0 on rd_data for rd_part >= PARTS or rd_addr >= N*N.
REQ-028 SHALL fill bits above ACCW in the top part per REQ-033/REQ-034.
REQ-029 SHALL keep results readable until overwritten by the next STORE; reads during CALC return current memory contents.
REQ-030 SHALL retain operand memory after DONE, so a new load overwrites it from word 0.

Reset
REQ-031 SHALL, on rst, regardless of state (including mid-LOAD or mid-CALC): enter IDLE, zero wptr, i, j, k, acc, result memory and rd_data, and drive busy=0 and done=0.
REQ-032 SHALL leave operand memory undefined after reset.

Configuration
REQ-033 SHALL, with MATMUL_SIGNED_EN defined, treat operands as two's complement, use a signed MAC, and sign-extend the top rd_data part above ACCW.
REQ-034 SHALL, without MATMUL_SIGNED_EN, treat operands as unsigned and zero-fill the top rd_data part above ACCW.

Verification (DW=8, N=3)
REQ-035 SHALL cover: load A=identity, B=1..9, start -> result[k]=k+1; parts 1,2 = 0x00; done 37 cycles after start.
REQ-036 SHALL cover: unsigned, A and B all 0xFF -> every result 195075; parts = 0x03, 0xFA, 0x02; rd_part=3 -> 0x00.
REQ-037 SHALL cover: MATMUL_SIGNED_EN, A all 0xFF (-1), B all 0x02 -> every result -6; parts = 0xFA, 0xFF, 0xFF.
REQ-038 SHALL cover: start after 17 words -> ignored, busy stays 0; 18th word plus start in the same cycle -> start ignored, state READY; a later start -> runs.
REQ-039 SHALL cover: rst at cycle 10 of CALC -> next cycle busy=0 and load_ready=1; all rd_data reads -> 0; a fresh load and start -> correct results.
REQ-040 SHALL cover: load_valid held high through CALC -> no words accepted and operand memory unchanged (results match the first run).
